// File: rtl/periph_bus_master.sv
// Initiator for the shared peripheral bus: one bus cycle per core request, response on a valid/ready channel.
// Optional: define PBM_TURNAROUND_EN to insert a dead bus cycle (TURN) after every issued write.
module periph_bus_master #(
    parameter logic [31:0] PERIPH_BASE = 32'hffff0000,
    parameter logic [31:0] PERIPH_MASK = 32'hffff0000,
    parameter logic [31:0] IDLE_ADDR   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data
);

`ifdef PBM_TURNAROUND_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3,
        ST_TURN  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
`ifdef PBM_TURNAROUND_EN
    logic        turn_pending_q, turn_pending_d;
`endif

    function automatic logic addr_legal(input logic [31:0] a);
        return ((a & PERIPH_MASK) == PERIPH_BASE) && (a[1:0] == 2'b00);
    endfunction

    // Next-state and next-output computation; every output is registered from its _d value.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef PBM_TURNAROUND_EN
        turn_pending_d = turn_pending_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = 32'h0000_0000;
`ifdef PBM_TURNAROUND_EN
                    turn_pending_d = addr_legal(req_addr) && req_we;
`endif
                    // Illegal requests skip the bus entirely and answer with an error.
                    if (!addr_legal(req_addr)) begin
                        state_d   = ST_RESP;
                        rsp_err_d = 1'b1;
                    end else if (req_we) begin
                        state_d   = ST_WRITE;
                        rsp_err_d = 1'b0;
                    end else begin
                        state_d   = ST_READ;
                        rsp_err_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_READ: begin
                state_d     = ST_RESP;
                rsp_rdata_d = mem_data;
            end
            ST_RESP: begin
                if (rsp_ready) begin
`ifdef PBM_TURNAROUND_EN
                    state_d = turn_pending_q ? ST_TURN : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_RESP;
                end
            end
`ifdef PBM_TURNAROUND_EN
            ST_TURN: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        mem_we_d    = (state_d == ST_WRITE);
        if ((state_d == ST_WRITE) || (state_d == ST_READ)) begin
            mem_addr_d = addr_d;
        end else begin
            mem_addr_d = IDLE_ADDR;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= IDLE_ADDR;
`ifdef PBM_TURNAROUND_EN
            turn_pending_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
`ifdef PBM_TURNAROUND_EN
            turn_pending_q <= turn_pending_d;
`endif
        end
    end

    // Drive enable comes straight from the state flop, so reset releases the bus on the same edge.
    assign mem_data  = (state_q == ST_WRITE) ? wdata_q : 32'bz;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;

endmodule
